// File: rtl/multi_cycle_mips_if.sv
// Instruction-load and observation bus of the multi-cycle MIPS core.
// The core takes the slave side; the loader/observer takes the master side.
interface multi_cycle_mips_if;
  logic        WE;
  logic [31:0] W_Ins;
  logic [31:0] PC;
  logic [31:0] nextPC;
  logic [31:0] Result;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Wdata;
  logic [2:0]  State;
  logic        Halt;

  modport master (
    output WE, W_Ins,
    input  PC, nextPC, Result, Rdata1, Rdata2, Wdata, State, Halt
  );

  modport slave (
    input  WE, W_Ins,
    output PC, nextPC, Result, Rdata1, Rdata2, Wdata, State, Halt
  );
endinterface

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt, addi, lw, sw, beq, j, halt)
// with word-indexed IMEM/DMEM and an instruction-load mode that freezes execution.
module multi_cycle_mips #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic               CLK,
  input logic               RST,
  multi_cycle_mips_if.slave bus
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MA   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     npc_q, npc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     imm_q, imm_d;
  logic [31:0]     result_q, result_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [IAW-1:0]  wptr_q, wptr_d;

  logic [31:0] rf_q   [32];
  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] dmem_q [DMEM_DEPTH];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        imem_we;
  logic        dmem_we;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val, imem_rd, dmem_rd;
  logic [31:0] alu_res;
  logic        r_valid;

  assign op      = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign rs_val  = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val  = (rt == 5'd0) ? '0 : rf_q[rt];
  assign imem_rd = imem_q[pc_q[IAW+1:2]];
  assign dmem_rd = dmem_q[result_q[DAW+1:2]];

  // Non-R opcodes all compute base+offset; unsupported R functs yield 0 and retire as NOP.
  always_comb begin
    alu_res = a_q + imm_q;
    r_valid = 1'b0;
    if (op == OP_R) begin
      alu_res = '0;
      r_valid = 1'b1;
      case (funct)
        FN_ADD:  alu_res = a_q + b_q;
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
        default: r_valid = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    result_d = result_q;
    wdata_d  = wdata_q;
    wptr_d   = wptr_q;
    rf_we    = 1'b0;
    rf_waddr = (op == OP_R) ? rd : rt;
    imem_we  = 1'b0;
    dmem_we  = 1'b0;

    if (bus.WE) begin
      imem_we = 1'b1;
      wptr_d  = wptr_q + IAW'(1);
    end else begin
      case (state_q)
        S_IF: begin
          ir_d    = imem_rd;
          npc_d   = pc_q + 32'd4;
          state_d = S_ID;
        end
        S_ID: begin
          a_d     = rs_val;
          b_d     = rt_val;
          imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
          state_d = (op == OP_HALT) ? S_HALT : S_EX;
        end
        S_EX: begin
          result_d = alu_res;
          state_d  = S_IF;
          case (op)
            OP_R: begin
              if (r_valid) begin
                wdata_d = alu_res;
                state_d = S_WB;
              end else begin
                pc_d = npc_q;
              end
            end
            OP_ADDI: begin
              wdata_d = alu_res;
              state_d = S_WB;
            end
            OP_LW, OP_SW: state_d = S_MA;
            OP_BEQ: pc_d = (a_q == b_q) ? npc_q + {imm_q[29:0], 2'b00} : npc_q;
            OP_J:   pc_d = {npc_q[31:28], ir_q[25:0], 2'b00};
            default: pc_d = npc_q;
          endcase
        end
        S_MA: begin
          if (op == OP_LW) begin
            wdata_d = dmem_rd;
            state_d = S_WB;
          end else begin
            dmem_we = 1'b1;
            pc_d    = npc_q;
            state_d = S_IF;
          end
        end
        S_WB: begin
          rf_we   = 1'b1;
          pc_d    = npc_q;
          state_d = S_IF;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IF;
      pc_q     <= RESET_PC;
      npc_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      wptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      wptr_q   <= wptr_d;
    end
  end

  // Storage is never cleared; reset only suppresses writes in its own cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (imem_we) imem_q[wptr_q] <= bus.W_Ins;
      if (dmem_we) dmem_q[result_q[DAW+1:2]] <= b_q;
      if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= wdata_q;
    end
  end

  assign bus.PC     = pc_q;
  assign bus.nextPC = npc_q;
  assign bus.Result = result_q;
  assign bus.Rdata1 = a_q;
  assign bus.Rdata2 = b_q;
  assign bus.Wdata  = wdata_q;
  assign bus.State  = state_q;
  assign bus.Halt   = (state_q == S_HALT);

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Directed program-level bench for multi_cycle_mips: loads small programs through
// the WE port and checks architectural outputs at hand-computed cycle points.
module tb_multi_cycle_mips;

  logic CLK = 1'b0;
  logic RST;

  multi_cycle_mips_if bus ();

  multi_cycle_mips #(
    .IMEM_DEPTH(256),
    .DMEM_DEPTH(256),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    bus.WE    = 1'b1;
    bus.W_Ins = w;
    tick(1);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    // Reset with WE high: reset must win
    RST = 1'b1; bus.WE = 1'b1; bus.W_Ins = 32'hDEAD_BEEF;
    tick(2);
    chk("rst_state",  {29'd0, bus.State}, 32'd0);
    chk("rst_pc",     bus.PC, 32'h0);
    chk("rst_npc",    bus.nextPC, 32'h0);
    chk("rst_result", bus.Result, 32'h0);
    chk("rst_wdata",  bus.Wdata, 32'h0);
    chk("rst_rdata1", bus.Rdata1, 32'h0);
    chk("rst_halt",   {31'd0, bus.Halt}, 32'd0);

    // Program 1: addi/addi/add/halt
    RST = 1'b0;
    load(itype(6'h08, 5'd1, 5'd0, 16'd5));
    chk("load_state_frozen", {29'd0, bus.State}, 32'd0);
    chk("load_pc_frozen", bus.PC, 32'h0);
    load(itype(6'h08, 5'd2, 5'd0, 16'd7));
    load(rtype(6'h20, 5'd3, 5'd1, 5'd2));
    load(HALT_W);
    bus.WE = 1'b0;
    tick(1);
    chk("p1_if_state", {29'd0, bus.State}, 32'd1);
    chk("p1_if_npc", bus.nextPC, 32'd4);
    tick(1);
    chk("p1_id_state", {29'd0, bus.State}, 32'd2);
    tick(1);
    chk("p1_ex_state", {29'd0, bus.State}, 32'd4);
    chk("p1_addi_result", bus.Result, 32'd5);
    chk("p1_addi_wdata", bus.Wdata, 32'd5);
    chk("p1_wb_pc_hold", bus.PC, 32'd0);
    tick(1);
    chk("p1_pc4", bus.PC, 32'd4);
    chk("p1_back_if", {29'd0, bus.State}, 32'd0);
    tick(8);
    chk("p1_pc12", bus.PC, 32'd12);
    chk("p1_add_result", bus.Result, 32'd12);
    chk("p1_add_wdata", bus.Wdata, 32'd12);
    tick(2);
    chk("p1_halt_state", {29'd0, bus.State}, 32'd7);
    chk("p1_halt", {31'd0, bus.Halt}, 32'd1);
    chk("p1_halt_pc", bus.PC, 32'd12);
    tick(3);
    chk("p1_halt_persist", {29'd0, bus.State}, 32'd7);

    // Program 2: memory, signed arithmetic, branches, jumps, NOPs
    RST = 1'b1; tick(1); RST = 1'b0;
    load(rtype(6'h20, 5'd8, 5'd3, 5'd0));          // 0  add $8,$3,$0
    load(itype(6'h08, 5'd3, 5'd0, 16'h1234));      // 4  addi $3,$0,0x1234
    load(itype(6'h2B, 5'd3, 5'd0, 16'd4));         // 8  sw $3,4($0)
    load(itype(6'h23, 5'd4, 5'd0, 16'd4));         // 12 lw $4,4($0)
    load(rtype(6'h20, 5'd9, 5'd4, 5'd0));          // 16 add $9,$4,$0
    load(itype(6'h08, 5'd5, 5'd0, 16'hFFFF));      // 20 addi $5,$0,-1
    load(rtype(6'h2A, 5'd6, 5'd5, 5'd0));          // 24 slt $6,$5,$0
    load(rtype(6'h20, 5'd7, 5'd5, 5'd5));          // 28 add $7,$5,$5
    load(itype(6'h04, 5'd2, 5'd1, 16'd5));         // 32 beq $1,$2,+5
    load({6'h02, 26'd11});                         // 36 j 44
    load(HALT_W);                                  // 40 skipped
    load(32'hF800_0000);                           // 44 opcode 0x3E -> NOP
    load(rtype(6'h00, 5'd13, 5'd1, 5'd2));         // 48 funct 0 -> NOP
    load(itype(6'h04, 5'd1, 5'd1, 16'hFFFF));      // 52 beq $1,$1,-1
    bus.WE = 1'b0;
    tick(3);
    chk("p2_rf3_kept_over_reset", bus.Result, 32'd12);
    tick(1);
    tick(4);
    chk("p2_addi_big", bus.Result, 32'h1234);
    chk("p2_pc8", bus.PC, 32'd8);
    tick(3);
    chk("p2_sw_ma_state", {29'd0, bus.State}, 32'd3);
    chk("p2_sw_addr", bus.Result, 32'd4);
    tick(1);
    chk("p2_sw_pc", bus.PC, 32'd12);
    chk("p2_sw_to_if", {29'd0, bus.State}, 32'd0);
    tick(4);
    chk("p2_lw_wb_state", {29'd0, bus.State}, 32'd4);
    chk("p2_lw_wdata", bus.Wdata, 32'h1234);
    chk("p2_lw_pc_hold", bus.PC, 32'd12);
    tick(1);
    chk("p2_lw_pc_5cyc", bus.PC, 32'd16);
    tick(3);
    chk("p2_rf4_rdata1", bus.Rdata1, 32'h1234);
    chk("p2_rf4_result", bus.Result, 32'h1234);
    tick(1);
    tick(4);
    chk("p2_addi_neg", bus.Result, 32'hFFFF_FFFF);
    chk("p2_pc24", bus.PC, 32'd24);
    tick(4);
    chk("p2_slt_signed", bus.Result, 32'd1);
    tick(4);
    chk("p2_add_wrap", bus.Result, 32'hFFFF_FFFE);
    chk("p2_pc32", bus.PC, 32'd32);
    tick(3);
    chk("p2_beq_ne_pc", bus.PC, 32'd36);
    chk("p2_beq_ne_if", {29'd0, bus.State}, 32'd0);
    tick(3);
    chk("p2_j_pc", bus.PC, 32'd44);
    tick(3);
    chk("p2_nop_op_pc", bus.PC, 32'd48);
    chk("p2_nop_wdata_hold", bus.Wdata, 32'hFFFF_FFFE);
    tick(3);
    chk("p2_nop_fn_pc", bus.PC, 32'd52);
    chk("p2_nop_fn_wdata_hold", bus.Wdata, 32'hFFFF_FFFE);
    tick(1);
    chk("p2_beq_loop_npc", bus.nextPC, 32'd56);
    tick(2);
    chk("p2_beq_loop_pc1", bus.PC, 32'd52);
    tick(3);
    chk("p2_beq_loop_pc2", bus.PC, 32'd52);

    // Program 3: reset during WB of add $3 must not write $3
    RST = 1'b1; tick(1); RST = 1'b0;
    load(rtype(6'h20, 5'd3, 5'd1, 5'd2));
    bus.WE = 1'b0;
    tick(3);
    chk("p3_in_wb", {29'd0, bus.State}, 32'd4);
    chk("p3_wb_result", bus.Result, 32'd12);
    RST = 1'b1; tick(1);
    chk("p3_abort_state", {29'd0, bus.State}, 32'd0);
    chk("p3_abort_pc", bus.PC, 32'd0);
    RST = 1'b0;
    load(rtype(6'h20, 5'd11, 5'd3, 5'd0));
    load(HALT_W);
    bus.WE = 1'b0;
    tick(3);
    chk("p3_rf3_unchanged", bus.Result, 32'h1234);
    tick(3);
    chk("p3_halt", {31'd0, bus.Halt}, 32'd1);

    // Program 4: IMEM_DEPTH+1 loads wrap onto word 0
    RST = 1'b1; tick(1); RST = 1'b0;
    for (int i = 0; i <= 256; i++) begin
      if (i == 0)        load(itype(6'h08, 5'd12, 5'd0, 16'd1));
      else if (i == 256) load(itype(6'h08, 5'd12, 5'd0, 16'd2));
      else               load(HALT_W);
      if ((i % 64) == 0) begin
        chk("p4_state_frozen", {29'd0, bus.State}, 32'd0);
        chk("p4_pc_frozen", bus.PC, 32'd0);
      end
    end
    bus.WE = 1'b0;
    tick(4);
    chk("p4_wrap_word0", bus.Result, 32'd2);
    chk("p4_pc4", bus.PC, 32'd4);
    tick(2);
    chk("p4_halt", {31'd0, bus.Halt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
